// File: rtl/score_pkg.sv
// Shared types and seven-segment patterns for the BCD score display.
// Patterns are active-high {a,b,c,d,e,f,g}; polarity is applied at the pins.
package score_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;

   function automatic logic [6:0] seg_encode(input bcd_digit_t digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder: a + b + cin, with decimal correction and carry out.
module bcd_digit_adder
   import score_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   output bcd_digit_t sum,
   output logic       cout
);

   logic [4:0] raw_sum;

   always_comb begin
      raw_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      sum     = raw_sum[3:0];
      cout    = 1'b0;
      // Binary results above 9 skip the six unused codes to wrap back into BCD
      if (raw_sum > 5'd9) begin
         sum  = raw_sum[3:0] + 4'd6;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_score_display.sv
// Saturating BCD score / high-score keeper driving a multiplexed 7-segment display.
// The scan advances on a clock-enable tick; seg/an are registered.
module bcd_score_display
   import score_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_HZ         = 100000000,
   parameter int REFRESH_HZ     = 400,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_score,
   input  logic                    inc,
   input  logic [3:0]              inc_by,
   input  logic                    show_high,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [4*NUM_DIGITS-1:0] score,
   output logic [4*NUM_DIGITS-1:0] high,
   output logic                    saturated
);

   localparam int DIV_RAW = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SEL_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SW      = 4 * NUM_DIGITS;

   localparam logic [SW-1:0]         ALL_NINES = {NUM_DIGITS{4'h9}};
   localparam logic [6:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = SEG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [SW-1:0]         score_q, score_d;
   logic [SW-1:0]         high_q, high_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic                  tick;
   bcd_digit_t            addend;
   logic [NUM_DIGITS:0]   carry;
   logic [SW-1:0]         sum_vec;

   logic [SW-1:0]         src;
   logic [NUM_DIGITS-1:0] blank;
   logic                  lead_zero;
   bcd_digit_t            cur_digit;
   logic                  cur_blank;
   logic [6:0]            seg_act;
   logic [NUM_DIGITS-1:0] an_act;

   always_comb begin
      tick  = (cnt_q == CNT_W'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      sel_d = sel_q;
      if (tick) begin
         sel_d = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
      end
   end

   // Ripple chain: the clamped addend enters digit 0, upper digits only add carries
   assign addend    = (inc_by > 4'd9) ? 4'd9 : inc_by;
   assign carry[0]  = 1'b0;
   assign saturated = (score_q == ALL_NINES);

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adder
      bcd_digit_adder u_adder (
         .a   (score_q[4*g +: 4]),
         .b   ((g == 0) ? addend : 4'd0),
         .cin (carry[g]),
         .sum (sum_vec[4*g +: 4]),
         .cout(carry[g+1])
      );
   end

   always_comb begin
      score_d = score_q;
      if (clr_score) begin
         score_d = '0;
      end else if (inc && !saturated) begin
         score_d = carry[NUM_DIGITS] ? ALL_NINES : sum_vec;
      end
      high_d = (score_q > high_q) ? score_q : high_q;
   end

   // A slot is blanked only if it and every digit above it are zero
   always_comb begin
      src       = show_high ? high_q : score_q;
      lead_zero = 1'b1;
      blank     = '0;
      cur_digit = '0;
      cur_blank = 1'b0;
      an_act    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lead_zero = lead_zero && (src[4*i +: 4] == 4'd0);
         blank[i]  = blank_lz && lead_zero && (i > 0);
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_q == SEL_W'(i)) begin
            cur_digit = src[4*i +: 4];
            cur_blank = blank[i];
            an_act[i] = !blank[i];
         end
      end
      seg_act = cur_blank ? 7'h00 : seg_encode(cur_digit);
      seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
      an_d    = SEG_ACTIVE_LOW ? ~an_act : an_act;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         sel_q   <= '0;
         score_q <= '0;
         high_q  <= '0;
         seg_q   <= SEG_OFF;
         an_q    <= AN_OFF;
      end else begin
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         score_q <= score_d;
         high_q  <= high_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign score = score_q;
   assign high  = high_q;

endmodule

// File: tb/tb_bcd_score_display.sv
// Self-checking bench for bcd_score_display: vector table, directed corner
// sequences and random increments checked against an integer score model.
module tb_bcd_score_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_score = 1'b0;
   logic        inc = 1'b0;
   logic [3:0]  inc_by = 4'd0;
   logic        show_high = 1'b0;
   logic        blank_lz = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] score;
   logic [15:0] high;
   logic        saturated;

   int checks = 0;
   int errors = 0;
   int model_score = 0;
   int model_high = 0;

   typedef struct {
      logic        clr;
      logic        inc;
      logic [3:0]  inc_by;
      logic [15:0] exp_score;
      logic [15:0] exp_high;
      logic        exp_sat;
   } vec_t;

   vec_t vecs[8];

   bcd_score_display #(
      .NUM_DIGITS    (4),
      .CLK_HZ        (1600),
      .REFRESH_HZ    (100),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr_score(clr_score),
      .inc      (inc),
      .inc_by   (inc_by),
      .show_high(show_high),
      .blank_lz (blank_lz),
      .seg      (seg),
      .an       (an),
      .score    (score),
      .high     (high),
      .saturated(saturated)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int e);
      int r = 1;
      for (int k = 0; k < e; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction

   function automatic logic [6:0] digit_pattern(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of score inputs and advance the integer model with it
   task automatic applyStimulus(input logic c, input logic i, input logic [3:0] b);
      int prev;
      clr_score = c;
      inc       = i;
      inc_by    = b;
      @(posedge clk);
      prev = model_score;
      if (c) begin
         model_score = 0;
      end else if (i) begin
         model_score = model_score + ((b > 4'd9) ? 9 : int'(b));
         if (model_score > 9999) model_score = 9999;
      end
      if (prev > model_high) model_high = prev;
      @(negedge clk);
      clr_score = 1'b0;
      inc       = 1'b0;
      inc_by    = 4'd0;
   endtask

   task automatic check_model(input string tag);
      checkOutput({tag, "_score"}, 32'(score), 32'(to_bcd(model_score)));
      checkOutput({tag, "_high"}, 32'(high), 32'(to_bcd(model_high)));
      checkOutput({tag, "_sat"}, 32'(saturated), 32'(model_score == 9999));
   endtask

   // Align to the start of a frame, then check every cycle of one full frame
   task automatic check_frame(input int src, input bit blank);
      logic [3:0] prev_an;
      logic [3:0] onehot;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      bit         found;
      bit         bl;
      int         slot;
      found   = 1'b0;
      prev_an = an;
      for (int w = 0; w < 64 && !found; w++) begin
         @(negedge clk);
         if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
         else prev_an = an;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL frame_align: got an=0x%0h, expected frame start 0xe", an);
         return;
      end
      for (int k = 0; k < 16; k++) begin
         slot    = k / 4;
         bl      = blank && (slot > 0) && ((src / pow10(slot)) == 0);
         onehot  = 4'b0001 << slot;
         exp_an  = bl ? 4'hF : ~onehot;
         exp_seg = bl ? 7'h7F : ~digit_pattern((src / pow10(slot)) % 10);
         checkOutput($sformatf("frame_an_k%0d", k), 32'(an), 32'(exp_an));
         checkOutput($sformatf("frame_seg_k%0d", k), 32'(seg), 32'(exp_seg));
         if (k < 15) @(negedge clk);
      end
   endtask

   initial begin
      logic [3:0] prev_an;
      bit         found;

      vecs[0] = '{1'b0, 1'b1, 4'd9,  16'h0009, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 4'd9,  16'h0018, 16'h0009, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 4'd9,  16'h0027, 16'h0018, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 4'd0,  16'h0027, 16'h0027, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 4'd12, 16'h0036, 16'h0027, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 4'd0,  16'h0036, 16'h0036, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 4'd5,  16'h0000, 16'h0036, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 4'd3,  16'h0003, 16'h0036, 1'b0};

      @(negedge clk);
      checkOutput("reset_seg", 32'(seg), 32'h7F);
      checkOutput("reset_an", 32'(an), 32'hF);
      checkOutput("reset_score", 32'(score), 32'h0);
      checkOutput("reset_high", 32'(high), 32'h0);
      checkOutput("reset_sat", 32'(saturated), 32'h0);
      rst = 1'b0;

      $display("[TB] vector table");
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].clr, vecs[v].inc, vecs[v].inc_by);
         checkOutput($sformatf("vec%0d_score", v), 32'(score), 32'(vecs[v].exp_score));
         checkOutput($sformatf("vec%0d_high", v), 32'(high), 32'(vecs[v].exp_high));
         checkOutput($sformatf("vec%0d_sat", v), 32'(saturated), 32'(vecs[v].exp_sat));
      end

      $display("[TB] saturation");
      applyStimulus(1'b1, 1'b0, 4'd0);
      while (model_score + 9 <= 9995) applyStimulus(1'b0, 1'b1, 4'd9);
      if (model_score < 9995) applyStimulus(1'b0, 1'b1, 4'(9995 - model_score));
      checkOutput("load_score", 32'(score), 32'h9995);
      checkOutput("load_sat", 32'(saturated), 32'h0);
      applyStimulus(1'b0, 1'b1, 4'd7);
      checkOutput("sat_score", 32'(score), 32'h9999);
      checkOutput("sat_flag", 32'(saturated), 32'h1);
      applyStimulus(1'b0, 1'b1, 4'd9);
      checkOutput("sat_hold_score", 32'(score), 32'h9999);
      checkOutput("sat_hold_flag", 32'(saturated), 32'h1);
      checkOutput("sat_hold_high", 32'(high), 32'h9999);

      $display("[TB] clear wins over inc");
      applyStimulus(1'b1, 1'b1, 4'd5);
      checkOutput("clr_score", 32'(score), 32'h0);
      checkOutput("clr_sat", 32'(saturated), 32'h0);
      checkOutput("clr_high", 32'(high), 32'h9999);
      show_high = 1'b1;
      blank_lz  = 1'b0;
      check_frame(model_high, 1'b0);

      $display("[TB] random increments");
      for (int r = 0; r < 300; r++) begin
         show_high = 1'($urandom % 2);
         blank_lz  = 1'($urandom % 2);
         applyStimulus(1'($urandom % 40 == 0), 1'($urandom % 2), 4'($urandom % 16));
         check_model($sformatf("rand%0d", r));
      end
      applyStimulus(1'b0, 1'b0, 4'd0);
      show_high = 1'($urandom % 2);
      blank_lz  = 1'b1;
      check_frame(show_high ? model_high : model_score, 1'b1);

      $display("[TB] leading-zero blanking");
      show_high = 1'b0;
      applyStimulus(1'b1, 1'b0, 4'd0);
      for (int r = 0; r < 4; r++) applyStimulus(1'b0, 1'b1, 4'd9);
      applyStimulus(1'b0, 1'b1, 4'd6);
      checkOutput("blank_score", 32'(score), 32'h0042);
      blank_lz = 1'b1;
      check_frame(model_score, 1'b1);
      blank_lz = 1'b0;
      check_frame(model_score, 1'b0);

      $display("[TB] reset mid-scan");
      found   = 1'b0;
      prev_an = an;
      for (int w = 0; w < 64 && !found; w++) begin
         @(negedge clk);
         if (an == 4'b0111 && prev_an != 4'b0111) found = 1'b1;
         else prev_an = an;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL slot3_align: got an=0x%0h, expected 0x7", an);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_seg", 32'(seg), 32'h7F);
      checkOutput("midrst_an", 32'(an), 32'hF);
      model_score = 0;
      model_high  = 0;
      @(negedge clk);
      @(negedge clk);
      check_model("midrst");
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("restart_an_k%0d", k), 32'(an),
                     (k <= 4) ? 32'hE : 32'hD);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
